float_issue_ctl: RTL and testbench
==================================

# float_issue_ctl

Sequencing controller for the shared floating-point datapath (ADDF, MULF, INVF, I2F, F2I units). It sits between the execute stage and the combinational float units. It accepts one float operation at a time over a valid/ready handshake and holds operands and opcode stable on the datapath for an op-dependent number of cycles. It then captures the result and presents it, with its destination register tag, over a second valid/ready handshake. While an op is in flight it reports busy and the destination tag so the pipeline hazard logic can stall dependents.

## Interface
Parameters:
- LAT_ADDF, 2: cycles from accept to result capture for ADDF (legal range 1..7)
- LAT_MULF, 3: the same, for MULF
- LAT_INVF, 2: the same, for INVF
- LAT_CVT, 1: the same, for I2F and F2I

Ports:
- clk  in  1  rising-edge clock; one clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  controller can accept
- req_op  in  4  opcode: ADDF=B, F2I=C, I2F=D, INVF=E, MULF=F
- req_a  in  16  operand A (ADDF/MULF first operand; I2F/F2I source)
- req_b  in  16  operand B (ADDF/MULF second operand; INVF source)
- req_dst  in  6  destination register index
- fu_op  out  4  opcode driven to the float datapath
- fu_a  out  16  operand A to the datapath
- fu_b  out  16  operand B to the datapath
- fu_result  in  16  combinational datapath result for fu_op/fu_a/fu_b
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_data  out  16  captured result
- res_dst  out  6  destination tag of res_data
- busy  out  1  an operation is in EXEC or DONE
- busy_dst  out  6  destination tag of the in-flight op (0 when not busy)
- illegal  out  1  one-cycle pulse: accepted opcode outside B..F

## Operation
- States: IDLE, EXEC, DONE.
- req_ready = (state==IDLE). A request is accepted at an edge where req_valid && req_ready.
- Accept with a legal op:
  - latch fu_op/fu_a/fu_b/busy_dst from req_op/req_a/req_b/req_dst;
  - load a 3-bit counter with the op latency minus 1;
  - go to EXEC.
- Accept with an illegal op: the controller stays in IDLE, latches no operands, and asserts illegal for exactly the next cycle. No result is produced.
- EXEC, counter != 0: decrement the counter.
- EXEC, counter == 0: capture res_data <= fu_result and res_dst <= busy_dst, then go to DONE.
- DONE:
  - res_valid=1;
  - res_data and res_dst are held;
  - on res_valid && res_ready, go to IDLE.
  - No new request is accepted in DONE.
- fu_op/fu_a/fu_b are held constant from accept until leaving DONE. They return to 0 on entry to IDLE.
- busy = (state!=IDLE). busy_dst is valid while busy and 0 otherwise.
- The controller does not interpret float data. Encoding on the datapath is sign[15], exponent[14:7] with bias 127, mantissa[6:0].

## Timing
- Reset values:
  - state IDLE;
  - req_ready=1 in the first cycle after reset;
  - fu_op=0, fu_a=0, fu_b=0;
  - res_valid=0, res_data=0, res_dst=0;
  - busy=0, busy_dst=0;
  - illegal=0.
- Accept at edge N:
  - result captured at edge N+L, where L is the op latency;
  - res_valid high from edge N+L until the handshake edge.
- res_ready held high: handshake at edge N+L+1, back in IDLE, next accept at edge N+L+2. Minimum issue interval is L+2 cycles.
- res_ready low: DONE holds indefinitely and all outputs stay stable.
- rst mid-operation (EXEC or DONE): abort at that edge. All outputs take their reset values and no result is delivered.
- rst and req_valid in the same cycle: rst wins and nothing is accepted.
- req_valid while not ready: ignored. The requester must hold req_* stable until accepted.

## Configuration
- FLOAT_ZERO_SHORTCUT_EN defined: for ADDF or MULF with req_a==16'h0000 or req_b==16'h0000, the latency is forced to 1, regardless of the LAT_* parameters. All other ops are unchanged.
- FLOAT_ZERO_SHORTCUT_EN undefined: every op uses its LAT_* parameter. No zero detection logic is present.

## Test plan
- MULF, a=4000 (2.0), b=4040 (3.0), dst=9, accept at edge 0, res_ready=1 -> res_valid high after edge 3 with res_data=40C0 (6.0), res_dst=9; busy and busy_dst=9 during cycles 1-3; IDLE after edge 4.
- ADDF 3F80+4000, then I2F a=0005 offered back-to-back -> second accept waits until req_ready returns; results 4040 then 40A0 in order; F2I a=4040 returns 0003 after one cycle.
- INVF b=4000 with res_ready held low for 10 cycles -> res_valid, res_data, res_dst and fu_* stay constant; req_ready=0 throughout; IDLE one edge after res_ready rises.
- req_op=1 (ADD) accepted -> illegal high for exactly one cycle; no res_valid; busy stays 0; next legal op accepted the following cycle.
- rst asserted in the second EXEC cycle of MULF -> all outputs return to reset values next cycle; no res_valid ever produced for that op.
- With FLOAT_ZERO_SHORTCUT_EN, MULF a=0000 b=4040 -> res_valid after edge 1 with res_data=0000; without the macro -> res_valid after edge 3.

Source files
------------

// File: rtl/float_issue_ctl.sv
// Float datapath issue controller: holds one op on the shared float units for an
// op-dependent latency, then hands the captured result off. Optional: FLOAT_ZERO_SHORTCUT_EN.
module float_issue_ctl #(
  parameter int unsigned LAT_ADDF = 2,
  parameter int unsigned LAT_MULF = 3,
  parameter int unsigned LAT_INVF = 2,
  parameter int unsigned LAT_CVT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [5:0]  req_dst,
  output logic [3:0]  fu_op,
  output logic [15:0] fu_a,
  output logic [15:0] fu_b,
  input  logic [15:0] fu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [5:0]  res_dst,
  output logic        busy,
  output logic [5:0]  busy_dst,
  output logic        illegal
);

  localparam logic [3:0] OP_ADDF = 4'hB;
  localparam logic [3:0] OP_F2I  = 4'hC;
  localparam logic [3:0] OP_I2F  = 4'hD;
  localparam logic [3:0] OP_INVF = 4'hE;
  localparam logic [3:0] OP_MULF = 4'hF;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  lat_m1;
  logic        accept;
  logic        op_legal;

  assign req_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign op_legal  = (req_op >= OP_ADDF);

  always_comb begin
    lat_m1 = '0;
    case (req_op)
      OP_ADDF:         lat_m1 = 3'(LAT_ADDF - 1);
      OP_MULF:         lat_m1 = 3'(LAT_MULF - 1);
      OP_INVF:         lat_m1 = 3'(LAT_INVF - 1);
      OP_F2I, OP_I2F:  lat_m1 = 3'(LAT_CVT - 1);
      default:         lat_m1 = '0;
    endcase
`ifdef FLOAT_ZERO_SHORTCUT_EN
    // A zero operand makes ADDF/MULF trivial, so the result is ready after one cycle.
    if ((req_op == OP_ADDF || req_op == OP_MULF) && (req_a == '0 || req_b == '0))
      lat_m1 = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && op_legal) state_nxt = EXEC;
      EXEC:    if (cnt == '0)          state_nxt = DONE;
      DONE:    if (res_ready)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fu_op    <= '0;
      fu_a     <= '0;
      fu_b     <= '0;
      busy_dst <= '0;
      cnt      <= '0;
      res_data <= '0;
      res_dst  <= '0;
      illegal  <= 1'b0;
    end else begin
      illegal <= accept && !op_legal;
      case (state)
        IDLE: begin
          if (accept && op_legal) begin
            fu_op    <= req_op;
            fu_a     <= req_a;
            fu_b     <= req_b;
            busy_dst <= req_dst;
            cnt      <= lat_m1;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 3'd1;
          end else begin
            res_data <= fu_result;
            res_dst  <= busy_dst;
          end
        end
        DONE: begin
          if (res_ready) begin
            fu_op    <= '0;
            fu_a     <= '0;
            fu_b     <= '0;
            busy_dst <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_issue_ctl.sv
// Self-checking bench for float_issue_ctl: directed scenarios plus randomized ops
// checked against a latency/result model derived from the opcode rules.
module tb_float_issue_ctl;

  localparam int unsigned LA = 2;
  localparam int unsigned LM = 3;
  localparam int unsigned LI = 2;
  localparam int unsigned LC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [5:0]  req_dst;
  logic [3:0]  fu_op;
  logic [15:0] fu_a, fu_b, fu_result;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic [5:0]  res_dst;
  logic        busy;
  logic [5:0]  busy_dst;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  float_issue_ctl #(.LAT_ADDF(LA), .LAT_MULF(LM), .LAT_INVF(LI), .LAT_CVT(LC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_dst(req_dst), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b),
    .fu_result(fu_result), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_dst(res_dst), .busy(busy), .busy_dst(busy_dst), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Stand-in float datapath: known vectors, otherwise an operand-sensitive mix.
  function automatic logic [15:0] fu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] mix;
    mix = a ^ {b[7:0], b[15:8]} ^ {op, op, op, op};
    case (op)
      4'hB: return (a == 16'h3F80 && b == 16'h4000) ? 16'h4040 : mix;
      4'hF: begin
        if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
        return (a == 16'h4000 && b == 16'h4040) ? 16'h40C0 : mix;
      end
      4'hD: return (a == 16'h0005) ? 16'h40A0 : mix;
      4'hC: return (a == 16'h4040) ? 16'h0003 : mix;
      4'hE: return (b == 16'h4000) ? 16'h3F00 : mix;
      default: return mix;
    endcase
  endfunction

  assign fu_result = fu_model(fu_op, fu_a, fu_b);

  // Latency per op; 0 means the opcode is illegal and produces no result.
  function automatic int lat(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
`ifdef FLOAT_ZERO_SHORTCUT_EN
    if ((op == 4'hB || op == 4'hF) && (a == 16'h0 || b == 16'h0)) return 1;
`endif
    case (op)
      4'hB: return int'(LA);
      4'hF: return int'(LM);
      4'hE: return int'(LI);
      4'hC, 4'hD: return int'(LC);
      default: return 0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [5:0] dst, input int hold, output logic [15:0] got);
    int L, cyc;
    logic [15:0] exp;
    L = lat(op, a, b);
    exp = fu_model(op, a, b);
    got = '0;
    res_ready = (hold == 0);
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_wait act=%b exp=1", req_ready); end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_dst = dst;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'($urandom); req_a = 16'($urandom); req_b = 16'($urandom); req_dst = 6'($urandom);
    if (L == 0) begin
      checks++; if ({illegal, busy, req_ready, res_valid} !== 4'b1010) begin
        errors++; $display("FAIL illegal_pulse op=%h act={ill,busy,rdy,rv}=%b exp=1010", op, {illegal, busy, req_ready, res_valid}); end
    end else begin
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_on_legal op=%h act=%b exp=0", op, illegal); end
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < 20) begin
        checks++; if ({busy, req_ready, busy_dst, fu_op, fu_a, fu_b} !== {1'b1, 1'b0, dst, op, a, b}) begin
          errors++; $display("FAIL exec_hold op=%h act=%b/%b/%h/%h/%h/%h exp=1/0/%h/%h/%h/%h",
                             op, busy, req_ready, busy_dst, fu_op, fu_a, fu_b, dst, op, a, b); end
        @(posedge clk); #1; cyc++;
      end
      checks++; if (cyc != L) begin errors++; $display("FAIL latency op=%h act=%0d exp=%0d", op, cyc, L); end
      for (int i = 0; i <= hold; i++) begin
        if (i == 0) got = res_data;
        checks++; if ({res_valid, res_data, res_dst, busy, busy_dst, req_ready, fu_op, fu_a, fu_b} !==
                      {1'b1, exp, dst, 1'b1, dst, 1'b0, op, a, b}) begin
          errors++; $display("FAIL done_hold op=%h i=%0d act=%b/%h/%h/%h/%h exp=1/%h/%h/%h/%h",
                             op, i, res_valid, res_data, res_dst, busy_dst, fu_op, exp, dst, dst, op); end
        if (i == hold) res_ready = 1'b1;
        @(posedge clk); #1;
      end
      checks++; if ({res_valid, busy, busy_dst, req_ready, fu_op, fu_a, fu_b} !== {1'b0, 1'b0, 6'd0, 1'b1, 4'd0, 16'd0, 16'd0}) begin
        errors++; $display("FAIL back_to_idle act=%b/%b/%h/%b/%h/%h/%h exp=0/0/00/1/0/0000/0000",
                           res_valid, busy, busy_dst, req_ready, fu_op, fu_a, fu_b); end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++; if ({req_ready, fu_op, fu_a, fu_b, res_valid, res_data, res_dst, busy, busy_dst, illegal} !==
                  {1'b1, 4'd0, 16'd0, 16'd0, 1'b0, 16'd0, 6'd0, 1'b0, 6'd0, 1'b0}) begin
      errors++; $display("FAIL %s act=rdy%b op%h a%h b%h rv%b rd%h rdst%h busy%b bdst%h ill%b exp=reset values",
                         tag, req_ready, fu_op, fu_a, fu_b, res_valid, res_data, res_dst, busy, busy_dst, illegal); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_dst = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_reset_vals("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("after_reset_release");
  endtask

  task automatic test_mulf();
    logic [15:0] got;
    issue(4'hF, 16'h4000, 16'h4040, 6'd9, 0, got);
    checks++; if (got !== 16'h40C0) begin errors++; $display("FAIL mulf_result act=%h exp=40c0", got); end
    issue(4'hC, 16'h4040, 16'h0000, 6'd3, 0, got);
    checks++; if (got !== 16'h0003) begin errors++; $display("FAIL f2i_result act=%h exp=0003", got); end
    issue(4'hF, 16'h0000, 16'h4040, 6'd12, 0, got);
    checks++; if (got !== 16'h0000) begin errors++; $display("FAIL mulf_zero_result act=%h exp=0000", got); end
  endtask

  task automatic test_back_to_back();
    int k1, k2, r1, r2, L1;
    logic [15:0] d1, d2;
    k1 = -1; k2 = -1; r1 = -1; r2 = -1; d1 = '0; d2 = '0;
    L1 = lat(4'hB, 16'h3F80, 16'h4000);
    res_ready = 1'b1;
    req_valid = 1'b1; req_op = 4'hB; req_a = 16'h3F80; req_b = 16'h4000; req_dst = 6'd1;
    @(posedge clk); #1;
    req_op = 4'hD; req_a = 16'h0005; req_b = 16'h1234; req_dst = 6'd2;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1 && res_dst === 6'd1 && r1 < 0) begin r1 = k; d1 = res_data; end
      if (res_valid === 1'b1 && res_dst === 6'd2 && r2 < 0) begin r2 = k; d2 = res_data; end
      if (busy_dst === 6'd2 && k2 < 0) begin k2 = k; req_valid = 1'b0; end
      if (busy_dst === 6'd1 && k1 < 0) k1 = k;
    end
    req_valid = 1'b0;
    checks++; if (r1 != L1) begin errors++; $display("FAIL b2b_first_latency act=%0d exp=%0d", r1, L1); end
    checks++; if (d1 !== 16'h4040) begin errors++; $display("FAIL b2b_first_data act=%h exp=4040", d1); end
    checks++; if (k2 != L1 + 2) begin errors++; $display("FAIL b2b_second_accept act=%0d exp=%0d", k2, L1 + 2); end
    checks++; if (r2 != L1 + 2 + int'(LC)) begin errors++; $display("FAIL b2b_second_latency act=%0d exp=%0d", r2, L1 + 2 + int'(LC)); end
    checks++; if (d2 !== 16'h40A0) begin errors++; $display("FAIL b2b_second_data act=%h exp=40a0", d2); end
  endtask

  task automatic test_stall();
    logic [15:0] got;
    issue(4'hE, 16'h0000, 16'h4000, 6'd33, 10, got);
    checks++; if (got !== 16'h3F00) begin errors++; $display("FAIL invf_result act=%h exp=3f00", got); end
  endtask

  task automatic test_illegal();
    logic [15:0] got;
    issue(4'h1, 16'h1111, 16'h2222, 6'd5, 0, got);
    issue(4'hB, 16'h3F80, 16'h4000, 6'd6, 0, got);
    issue(4'hA, 16'h0000, 16'h0000, 6'd7, 0, got);
    @(posedge clk); #1;
    checks++; if ({illegal, busy, res_valid, req_ready} !== 4'b0001) begin
      errors++; $display("FAIL illegal_one_cycle act={ill,busy,rv,rdy}=%b exp=0001", {illegal, busy, res_valid, req_ready}); end
  endtask

  task automatic test_abort();
    int seen;
    res_ready = 1'b1;
    req_valid = 1'b1; req_op = 4'hF; req_a = 16'h4000; req_b = 16'h4040; req_dst = 6'd21;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("abort_reset_values");
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (res_valid !== 1'b0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_result act=%0d exp=0", seen); end
    rst = 1'b1; req_valid = 1'b1; req_op = 4'hC; req_a = 16'h4040; req_dst = 6'd4;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    check_reset_vals("rst_beats_req");
    @(posedge clk); #1;
    checks++; if ({busy, res_valid} !== 2'b00) begin errors++; $display("FAIL rst_beats_req_late act=%b exp=00", {busy, res_valid}); end
  endtask

  task automatic test_random();
    logic [3:0] ops [10];
    logic [15:0] got, a, b;
    ops = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h0, 4'hA, 4'hB, 4'hF};
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      issue(ops[$urandom_range(0, 9)], a, b, 6'($urandom), int'($urandom_range(0, 3)), got);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_mulf();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
